// File: rtl/mux_scanner_if.sv
// Bus bundle for mux_scanner: channel inputs, control and the registered
// selection result. The master side drives inputs and the slave side is the scanner.
interface mux_scanner_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  parameter int ADDR_W   = 3,
  parameter int DWELL_W  = 8
);
  logic                      mode;
  logic [ADDR_W-1:0]         address;
  logic [CHANNELS*WIDTH-1:0] data;
  logic [CHANNELS-1:0]       enable_mask;
  logic [DWELL_W-1:0]        dwell;
  logic                      start;
  logic [WIDTH-1:0]          out;
  logic [ADDR_W-1:0]         out_addr;
  logic                      out_valid;
  logic                      busy;
  logic                      wrap;

  modport master (
    output mode, address, data, enable_mask, dwell, start,
    input  out, out_addr, out_valid, busy, wrap
  );

  modport slave (
    input  mode, address, data, enable_mask, dwell, start,
    output out, out_addr, out_valid, busy, wrap
  );
endinterface

// File: rtl/mux_scanner.sv
// N-channel registered multiplexer with DIRECT (address-selected) and
// SCAN (mask-driven sequencer with programmable dwell) modes.
module mux_scanner #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  parameter int ADDR_W   = 3,
  parameter int DWELL_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_scanner_if.slave   bus
);

  localparam int NSLOT = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    cur_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     out_q;
  logic [ADDR_W-1:0]    out_addr_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 wrap_q;

  // Mask and data padded to the full address space so any address indexes safely.
  logic [NSLOT-1:0]       mask_pad;
  logic [NSLOT*WIDTH-1:0] data_pad;
  logic [ADDR_W:0]        first_d;
  logic [ADDR_W:0]        next_d;
  logic                   first_found;
  logic                   next_found;
  logic [ADDR_W-1:0]      first_idx;
  logic [ADDR_W-1:0]      next_idx;

  // Rotate-and-priority-encode: first enabled index at or after base, modulo CHANNELS.
  // Result is {found, index}.
  function automatic logic [ADDR_W:0] find_from(input logic [CHANNELS-1:0] m, input int base);
    logic              found;
    logic [ADDR_W-1:0] res;
    int                idx;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (base + k) % CHANNELS;
      if (!found && m[idx]) begin
        found = 1'b1;
        res   = idx[ADDR_W-1:0];
      end
    end
    return {found, res};
  endfunction

  // Padding of mask/data and the two combinational channel searches.
  always_comb begin
    mask_pad = '0;
    mask_pad[CHANNELS-1:0] = bus.enable_mask;
    data_pad = '0;
    data_pad[CHANNELS*WIDTH-1:0] = bus.data;
    first_d = find_from(bus.enable_mask, 0);
    next_d  = find_from(bus.enable_mask, int'(cur_q) + 1);
  end

  assign first_found = first_d[ADDR_W];
  assign first_idx   = first_d[ADDR_W-1:0];
  assign next_found  = next_d[ADDR_W];
  assign next_idx    = next_d[ADDR_W-1:0];

  // Scan FSM, dwell counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.mode) begin
            if (bus.start) begin
              if (!first_found) begin
                out_valid_q <= 1'b0;
              end else begin
                cur_q   <= first_idx;
                cnt_q   <= bus.dwell;
                state_q <= DWELL;
                busy_q  <= 1'b1;
              end
            end
          end else if ((int'(bus.address) < CHANNELS) && mask_pad[bus.address]) begin
            out_q       <= data_pad[bus.address*WIDTH +: WIDTH];
            out_addr_q  <= bus.address;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        DWELL: begin
          if (!bus.mode) begin
            // Leaving SCAN: outputs hold, DIRECT takes over from the next cycle.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            out_q       <= data_pad[cur_q*WIDTH +: WIDTH];
            out_addr_q  <= cur_q;
            out_valid_q <= 1'b1;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (next_found) begin
              cur_q  <= next_idx;
              cnt_q  <= bus.dwell;
              wrap_q <= (next_idx <= cur_q);
            end else begin
              // Mask emptied during the dwell: abandon the scan quietly.
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner: an 8-channel instance exercises DIRECT,
// SCAN, reset and mode exit; a 6-channel instance covers out-of-range addresses.
module tb_mux_scanner;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mux_scanner_if #(.CHANNELS(8), .WIDTH(1), .ADDR_W(3), .DWELL_W(8)) if8 ();
  mux_scanner_if #(.CHANNELS(6), .WIDTH(1), .ADDR_W(3), .DWELL_W(8)) if6 ();

  mux_scanner #(.CHANNELS(8), .WIDTH(1), .ADDR_W(3), .DWELL_W(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  mux_scanner #(.CHANNELS(6), .WIDTH(1), .ADDR_W(3), .DWELL_W(8)) u6 (
    .clk (clk),
    .rst (rst),
    .bus (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_addr3 [7] = '{2, 2, 2, 5, 5, 5, 2};
  int exp_wrap3 [7] = '{0, 0, 0, 0, 0, 1, 0};
  int exp_out3  [7] = '{1, 1, 1, 0, 1, 1, 1};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    if8.mode = 1'b0; if8.address = '0; if8.data = '0; if8.enable_mask = '0;
    if8.dwell = '0; if8.start = 1'b0;
    if6.mode = 1'b0; if6.address = '0; if6.data = '0; if6.enable_mask = '0;
    if6.dwell = '0; if6.start = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(if8.out_valid), 0);
    chk("rst_busy",  32'(if8.busy), 0);
    chk("rst_addr",  32'(if8.out_addr), 0);
    chk("rst_wrap",  32'(if8.wrap), 0);
    rst = 1'b0;

    // 1: DIRECT select
    if8.enable_mask = 8'hFF; if8.data = 8'h20; if8.address = 3'd5;
    tick();
    chk("dir_out",   32'(if8.out), 1);
    chk("dir_addr",  32'(if8.out_addr), 5);
    chk("dir_valid", 32'(if8.out_valid), 1);
    if8.address = 3'd3;
    tick();
    chk("dir3_out",  32'(if8.out), 0);
    chk("dir3_addr", 32'(if8.out_addr), 3);
    // Masked-off channel: invalid, held
    if8.enable_mask = 8'hF7;
    tick();
    chk("dirmask_valid", 32'(if8.out_valid), 0);
    chk("dirmask_addr",  32'(if8.out_addr), 3);
    if8.enable_mask = 8'hFF;

    // 2: SCAN every channel, dwell 0
    if8.mode = 1'b1; if8.dwell = 8'd0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk("scan_busy0", 32'(if8.busy), 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("scan_addr%0d", i), 32'(if8.out_addr), 32'(i % 8));
      chk($sformatf("scan_wrap%0d", i), 32'(if8.wrap), (i == 7) ? 1 : 0);
      chk($sformatf("scan_out%0d", i),  32'(if8.out), ((i % 8) == 5) ? 1 : 0);
      chk($sformatf("scan_busy%0d", i), 32'(if8.busy), 1);
    end

    // 6: leave SCAN, then DIRECT selection
    if8.mode = 1'b0; if8.address = 3'd5;
    tick();
    chk("exit_busy", 32'(if8.busy), 0);
    tick();
    chk("exit_dir_addr",  32'(if8.out_addr), 5);
    chk("exit_dir_valid", 32'(if8.out_valid), 1);
    chk("exit_dir_out",   32'(if8.out), 1);

    // 3: sparse mask with dwell 2 and a mid-dwell data change
    if8.mode = 1'b1; if8.enable_mask = 8'h24; if8.dwell = 8'd2; if8.data = 8'h04;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("dw_addr%0d", i), 32'(if8.out_addr), 32'(exp_addr3[i]));
      chk($sformatf("dw_wrap%0d", i), 32'(if8.wrap), 32'(exp_wrap3[i]));
      chk($sformatf("dw_out%0d", i),  32'(if8.out), 32'(exp_out3[i]));
      if (i == 3) if8.data = 8'h24;
    end

    // 5: asynchronous reset between edges mid-DWELL
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out",   32'(if8.out), 0);
    chk("arst_addr",  32'(if8.out_addr), 0);
    chk("arst_valid", 32'(if8.out_valid), 0);
    chk("arst_busy",  32'(if8.busy), 0);
    chk("arst_wrap",  32'(if8.wrap), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_busy",  32'(if8.busy), 0);
    chk("post_rst_valid", 32'(if8.out_valid), 0);

    // 4: empty mask start is refused
    if8.enable_mask = 8'h00; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk("empty_busy",  32'(if8.busy), 0);
    chk("empty_valid", 32'(if8.out_valid), 0);
    tick();
    chk("empty_busy2", 32'(if8.busy), 0);

    // 4: six-channel instance, out-of-range address holds output
    if6.enable_mask = 6'h3F; if6.data = 6'b010000; if6.address = 3'd4;
    tick();
    chk("c6_out",   32'(if6.out), 1);
    chk("c6_addr",  32'(if6.out_addr), 4);
    chk("c6_valid", 32'(if6.out_valid), 1);
    if6.address = 3'd7; if6.data = 6'b000000;
    tick();
    chk("c6_oor_valid", 32'(if6.out_valid), 0);
    chk("c6_oor_out",   32'(if6.out), 1);
    chk("c6_oor_addr",  32'(if6.out_addr), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
